sd_dma_ctrl: RTL and testbench
==============================

Name: sd_dma_ctrl

Overview:
Parametrised bidirectional DMA engine between the SD data FIFOs and the shared memory bus.
- Write direction (SD to memory): pops the RX FIFO and issues bus writes.
- Read direction (memory to SD): issues pipelined bus reads with multiple outstanding requests and pushes the returned data into the TX FIFO under credit-based flow control.
- Sits between the SD controller FIFOs and the bus arbiter; configured by the SD register block.

Parameters:
DATA_WIDTH, 32, bus and FIFO word width
ADDR_WIDTH, 24, word address width
BANK_WIDTH, 4, bank select width
LEN_WIDTH, 15, transfer length counter width (words)
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged reads (1..15)
FREE_WIDTH, 6, width of TX FIFO free-entry count

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_dma_bank  in  BANK_WIDTH  start bank
i_dma_address  in  ADDR_WIDTH  start word address
i_dma_length  in  LEN_WIDTH  transfer length in words
i_dma_load_bank_address  in  1  load bank and address (ignored while busy)
i_dma_load_length  in  1  load length (ignored while busy)
i_dma_direction  in  1  1 = write to memory, 0 = read from memory; sampled on an accepted start
i_dma_start  in  1  start pulse
i_dma_stop  in  1  abort pulse
o_dma_left  out  LEN_WIDTH  words not yet requested
o_dma_busy  out  1  engine active (RUN or DRAIN)
o_dma_done  out  1  one-cycle pulse on return to IDLE
o_rx_fifo_pop  out  1  pop RX FIFO
i_rx_fifo_empty  in  1  RX FIFO empty
i_rx_fifo_data  in  DATA_WIDTH  RX FIFO head word
o_tx_fifo_push  out  1  push TX FIFO (registered)
i_tx_fifo_free  in  FREE_WIDTH  TX FIFO free entries, excluding any push this cycle
o_tx_fifo_data  out  DATA_WIDTH  TX FIFO data (registered)
o_request  out  1  bus request
o_write  out  1  bus direction
i_busy  in  1  bus stall; a request is accepted when o_request && !i_busy
i_ack  in  1  read data valid
o_bank  out  BANK_WIDTH  bus bank
o_address  out  ADDR_WIDTH  bus word address
i_data  in  DATA_WIDTH  bus read data
o_data  out  DATA_WIDTH  bus write data (= i_rx_fifo_data)

Behaviour:
- Reset (async, i_reset_n low): state IDLE. All registers and outputs are 0: busy, done, write, bank, address, remaining, outstanding, push, tx data.
- Definition: accept = o_request && !i_busy.
- States:
  - IDLE: load strobes act. On i_dma_start:
    - remaining == 0: stay IDLE, pulse done next cycle, busy stays 0.
    - otherwise: go to RUN, o_write <= i_dma_direction.
  - Start while busy is ignored. Load strobes while busy are ignored.
- RUN, write direction:
  - o_request = !i_rx_fifo_empty && remaining != 0 (combinational).
  - o_rx_fifo_pop = accept.
- RUN, read direction:
  - o_request = remaining != 0 && outstanding < MAX_OUTSTANDING && i_tx_fifo_free > outstanding + o_tx_fifo_push.
  - This credit rule means the TX FIFO never overflows.
- Every accept: address += 1, wrapping modulo 2^ADDR_WIDTH with bank unchanged; remaining -= 1.
- Outstanding counter (read direction): +1 on accept, -1 on i_ack. Both in the same cycle leaves it unchanged.
- i_ack in read direction: next cycle o_tx_fifo_push = 1 and o_tx_fifo_data = i_data (latency 1).
- i_ack in IDLE or write direction: ignored.
- Completion:
  - Write: the cycle after the accept that makes remaining 0, go to IDLE.
  - Read: when remaining == 0, outstanding == 0 and no push is pending, go to IDLE.
  - o_dma_done pulses for one cycle on entering IDLE.
- i_dma_stop in RUN:
  - No further requests from the next cycle.
  - outstanding > 0: go to DRAIN.
  - otherwise: go to IDLE with a done pulse.
  - remaining is frozen (not cleared) so firmware can read the leftover count.
- DRAIN: o_request = 0. Acks still push to the TX FIFO. Go to IDLE with a done pulse when outstanding reaches 0 and the last push has been issued.
- i_dma_stop in IDLE or DRAIN: ignored.
- Stop and accept in the same cycle: the accept counts (address and remaining update).
- o_dma_busy = state != IDLE, registered.
- o_dma_left = remaining.
- o_address and o_bank hold their values when idle.

Test Plan:
- Write direction: bank 2, address 0x000010, length 3, RX FIFO holds 3 words, i_busy low -> 3 consecutive accepts at 0x10..0x12, 3 pops, done pulse, left = 0, busy 0 next cycle.
- Read with bus latency 3 and MAX_OUTSTANDING 4: length 8, free 16 -> at most 4 outstanding; 8 TX pushes in address order, each 1 cycle after its ack, data matching memory.
- TX credit limit: read length 6, free held at 2 -> never more than 2 (outstanding + pending push); raise free to 16 -> transfer completes with no overflow.
- Stop mid-read: length 10, stop after 5 accepts with 3 outstanding -> no new requests, DRAIN absorbs 3 acks into 3 pushes, then done; left = 5.
- Address wrap: address 0xFFFFFE, length 4 write -> addresses FFFFFE, FFFFFF, 000000, 000001; bank unchanged.
- Start with length 0 -> busy stays 0, done pulse, no request. Separately, assert reset mid-transfer -> all outputs 0 immediately; a following start works normally.

Source files
------------

// File: rtl/sd_dma_ctrl.sv
// sd_dma_ctrl
//   Bidirectional DMA engine between the SD data FIFOs and the shared memory
//   bus. In the write direction it pops the RX FIFO and issues one bus write
//   per word. In the read direction it keeps up to MAX_OUTSTANDING reads in
//   flight. It pushes each returned word into the TX FIFO one cycle after its
//   ack, and uses the TX FIFO free count as credit so that FIFO never
//   overflows.
//
// Ports
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_dma_bank/address/length  configuration, latched by the load strobes in IDLE
//   i_dma_direction            1 = SD to memory (bus write), 0 = memory to SD
//   i_dma_start, i_dma_stop    start / abort pulses
//   o_dma_left                 words not yet requested
//   o_dma_busy, o_dma_done     engine active, one-cycle completion pulse
//   o_rx_fifo_pop, i_rx_fifo_* RX FIFO side (write direction)
//   o_tx_fifo_*, i_tx_fifo_free TX FIFO side (read direction), registered push
//   o_request, o_write, i_busy bus handshake; accept = o_request && !i_busy
//   i_ack, i_data              read return, in request order
//   o_bank, o_address, o_data  bus address and write data
module sd_dma_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 24,
  parameter int BANK_WIDTH      = 4,
  parameter int LEN_WIDTH       = 15,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FREE_WIDTH      = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [BANK_WIDTH-1:0] i_dma_bank,
  input  logic [ADDR_WIDTH-1:0] i_dma_address,
  input  logic [LEN_WIDTH-1:0]  i_dma_length,
  input  logic                  i_dma_load_bank_address,
  input  logic                  i_dma_load_length,
  input  logic                  i_dma_direction,
  input  logic                  i_dma_start,
  input  logic                  i_dma_stop,
  output logic [LEN_WIDTH-1:0]  o_dma_left,
  output logic                  o_dma_busy,
  output logic                  o_dma_done,
  output logic                  o_rx_fifo_pop,
  input  logic                  i_rx_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_rx_fifo_data,
  output logic                  o_tx_fifo_push,
  input  logic [FREE_WIDTH-1:0] i_tx_fifo_free,
  output logic [DATA_WIDTH-1:0] o_tx_fifo_data,
  output logic                  o_request,
  output logic                  o_write,
  input  logic                  i_busy,
  input  logic                  i_ack,
  output logic [BANK_WIDTH-1:0] o_bank,
  output logic [ADDR_WIDTH-1:0] o_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  // Wide enough that outstanding + pending push never wraps against the free count.
  localparam int CMP_WIDTH = ((FREE_WIDTH > OUT_WIDTH) ? FREE_WIDTH : OUT_WIDTH) + 1;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [OUT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  req;
  logic                  accept;
  logic                  ack_valid;
  logic                  rem_nz;
  logic                  read_active;
  logic [CMP_WIDTH-1:0]  credit_used;
  logic [CMP_WIDTH-1:0]  credit_free;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      bank_q        <= '0;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      push_q        <= 1'b0;
      tx_data_q     <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      bank_q        <= bank_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      push_q        <= push_d;
      tx_data_q     <= tx_data_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    bank_d        = bank_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    push_d        = 1'b0;
    tx_data_d     = tx_data_q;
    done_d        = 1'b0;
    req           = 1'b0;

    rem_nz      = (remaining_q != '0);
    read_active = !write_q && (state_q != ST_IDLE);
    credit_used = CMP_WIDTH'(outstanding_q) + CMP_WIDTH'(push_q);
    credit_free = CMP_WIDTH'(i_tx_fifo_free);

    // Reads only go out while every in-flight word plus the pending push
    // still has a guaranteed slot in the TX FIFO.
    if (state_q == ST_RUN) begin
      if (write_q) begin
        req = !i_rx_fifo_empty && rem_nz;
      end else begin
        req = rem_nz && (outstanding_q < OUT_MAX) && (credit_free > credit_used);
      end
    end
    accept    = req && !i_busy;
    ack_valid = i_ack && read_active;

    if (accept) begin
      addr_d      = addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end

    // Accept and ack in the same cycle cancel out.
    if (read_active) begin
      if (accept && !ack_valid) begin
        outstanding_d = outstanding_q + OUT_WIDTH'(1);
      end else if (!accept && ack_valid && (outstanding_q != '0)) begin
        outstanding_d = outstanding_q - OUT_WIDTH'(1);
      end
    end

    if (ack_valid) begin
      push_d    = 1'b1;
      tx_data_d = i_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_dma_load_bank_address) begin
          bank_d = i_dma_bank;
          addr_d = i_dma_address;
        end
        if (i_dma_load_length) begin
          remaining_d = i_dma_length;
        end
        if (i_dma_start) begin
          if (rem_nz) begin
            state_d = ST_RUN;
            write_d = i_dma_direction;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (write_q) begin
          if (!rem_nz || (accept && (remaining_q == LEN_WIDTH'(1)))) begin
            state_d = ST_IDLE;
          end
        end else if (!rem_nz && (outstanding_q == '0) && !push_q) begin
          state_d = ST_IDLE;
        end
        // Abort: the accept of this cycle (if any) still counts, and
        // remaining is left as-is so firmware can read the leftover.
        if (i_dma_stop) begin
          state_d = (outstanding_d != '0) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == '0) && !push_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      done_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign o_request      = req;
  assign o_rx_fifo_pop  = accept && write_q;
  assign o_data         = i_rx_fifo_data;
  assign o_write        = write_q;
  assign o_bank         = bank_q;
  assign o_address      = addr_q;
  assign o_dma_left     = remaining_q;
  assign o_dma_busy     = busy_q;
  assign o_dma_done     = done_q;
  assign o_tx_fifo_push = push_q;
  assign o_tx_fifo_data = tx_data_q;

endmodule

// File: tb/tb_sd_dma_ctrl.sv
// tb_sd_dma_ctrl
//   Self-checking bench for sd_dma_ctrl. A bus/FIFO responder drives the
//   environment just after each rising edge. A monitor on the falling edge
//   records accepts, acks, pushes, pops and done pulses, and keeps its own
//   count of in-flight reads. Each test task compares what was recorded
//   against expectations computed from the transfer parameters.
module tb_sd_dma_ctrl;

  localparam int DW = 32, AW = 24, BW = 4, LW = 15, MAXO = 4, FW = 6;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [BW-1:0] i_dma_bank = '0;
  logic [AW-1:0] i_dma_address = '0;
  logic [LW-1:0] i_dma_length = '0;
  logic          i_dma_load_bank_address = 1'b0, i_dma_load_length = 1'b0;
  logic          i_dma_direction = 1'b0, i_dma_start = 1'b0, i_dma_stop = 1'b0;
  logic [LW-1:0] o_dma_left;
  logic          o_dma_busy, o_dma_done, o_rx_fifo_pop;
  logic          i_rx_fifo_empty = 1'b1;
  logic [DW-1:0] i_rx_fifo_data = '0;
  logic          o_tx_fifo_push;
  logic [FW-1:0] i_tx_fifo_free = '0;
  logic [DW-1:0] o_tx_fifo_data;
  logic          o_request, o_write;
  logic          i_busy = 1'b0, i_ack = 1'b0;
  logic [BW-1:0] o_bank;
  logic [AW-1:0] o_address;
  logic [DW-1:0] i_data = '0;
  logic [DW-1:0] o_data;

  always #5 clk = ~clk;

  sd_dma_ctrl dut (
    .i_clk(clk), .i_reset_n(rstN),
    .i_dma_bank(i_dma_bank), .i_dma_address(i_dma_address), .i_dma_length(i_dma_length),
    .i_dma_load_bank_address(i_dma_load_bank_address), .i_dma_load_length(i_dma_load_length),
    .i_dma_direction(i_dma_direction), .i_dma_start(i_dma_start), .i_dma_stop(i_dma_stop),
    .o_dma_left(o_dma_left), .o_dma_busy(o_dma_busy), .o_dma_done(o_dma_done),
    .o_rx_fifo_pop(o_rx_fifo_pop), .i_rx_fifo_empty(i_rx_fifo_empty), .i_rx_fifo_data(i_rx_fifo_data),
    .o_tx_fifo_push(o_tx_fifo_push), .i_tx_fifo_free(i_tx_fifo_free), .o_tx_fifo_data(o_tx_fifo_data),
    .o_request(o_request), .o_write(o_write), .i_busy(i_busy), .i_ack(i_ack),
    .o_bank(o_bank), .o_address(o_address), .i_data(i_data), .o_data(o_data)
  );

  int testsRun = 0, testsFailed = 0;
  int cyc = 0;

  // Environment knobs (-1 budget = unlimited)
  int grantBudget = -1, ackBudget = -1;
  int lat = 1, latJitter = 0, busyRand = 0, rxStallRand = 0, strayAck = 0;
  int rxAvail = 0, freeVal = 16, startCyc = 0;
  logic [31:0] rxSalt = 32'h1234_5678;

  // Observations
  logic [BW+AW-1:0] accAddrQ[$];
  logic [DW-1:0]    accDataQ[$];
  logic             accWriteQ[$];
  int               accCycQ[$];
  int               ackCycQ[$];
  logic [DW-1:0]    pushDataQ[$];
  int               pushCycQ[$];
  int popCount = 0, doneCount = 0, doneCyc = 0, busyAtDone = 0, reqHigh = 0, busyHigh = 0;
  int modelOut = 0, peakOut = 0, peakUse = 0, violations = 0, lastDue = 0;
  logic ackReal = 1'b0;

  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t rspQ[$];

  function automatic logic [DW-1:0] memWord(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return {b, 4'h9, a} ^ 32'h5A3C_0F17;
  endfunction

  function automatic logic [DW-1:0] rxWord(input int i);
    return rxSalt + (32'(i) * 32'h0101_0107);
  endfunction

  // Responder: memory with in-order read returns, RX FIFO source, TX free count
  always @(posedge clk) begin
    #1;
    cyc++;
    i_ack = 1'b0;
    ackReal = 1'b0;
    i_data = $urandom;
    if (rstN && ackBudget != 0 && rspQ.size() > 0 && rspQ[0].due <= cyc) begin
      i_ack = 1'b1;
      ackReal = 1'b1;
      i_data = rspQ[0].data;
      void'(rspQ.pop_front());
    end else if (rstN && strayAck != 0 && $urandom_range(0, 2) == 0) begin
      i_ack = 1'b1;
    end
    i_busy = (grantBudget == 0) ? 1'b1 : ((busyRand != 0) ? ($urandom_range(0, 2) == 0) : 1'b0);
    i_rx_fifo_empty = (popCount >= rxAvail) || (rxStallRand != 0 && $urandom_range(0, 3) == 0);
    i_rx_fifo_data = rxWord(popCount);
    i_tx_fifo_free = FW'(freeVal);
  end

  // Monitor: records events and checks the credit / outstanding invariants
  always @(negedge clk) begin
    int due;
    if (rstN) begin
      if (modelOut > MAXO || modelOut + int'(o_tx_fifo_push) > int'(i_tx_fifo_free)) violations++;
      if (modelOut > peakOut) peakOut = modelOut;
      if (modelOut + int'(o_tx_fifo_push) > peakUse) peakUse = modelOut + int'(o_tx_fifo_push);
      if (o_request) reqHigh++;
      if (o_dma_busy) busyHigh++;
      if (o_request && !i_busy) begin
        accAddrQ.push_back({o_bank, o_address});
        accDataQ.push_back(o_data);
        accWriteQ.push_back(o_write);
        accCycQ.push_back(cyc);
        if (grantBudget > 0) grantBudget--;
        if (!o_write) begin
          due = cyc + lat + int'($urandom_range(0, latJitter));
          if (due <= lastDue) due = lastDue + 1;
          lastDue = due;
          rspQ.push_back('{due, memWord(o_bank, o_address)});
          modelOut++;
        end
      end
      if (i_ack && ackReal) begin
        ackCycQ.push_back(cyc);
        modelOut--;
        if (ackBudget > 0) ackBudget--;
      end
      if (o_tx_fifo_push) begin
        pushDataQ.push_back(o_tx_fifo_data);
        pushCycQ.push_back(cyc);
      end
      if (o_rx_fifo_pop) popCount++;
      if (o_dma_done) begin
        doneCount++;
        doneCyc = cyc;
        busyAtDone = int'(o_dma_busy);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearObs();
    accAddrQ.delete(); accDataQ.delete(); accWriteQ.delete(); accCycQ.delete();
    ackCycQ.delete(); pushDataQ.delete(); pushCycQ.delete(); rspQ.delete();
    popCount = 0; doneCount = 0; doneCyc = 0; busyAtDone = 0; reqHigh = 0; busyHigh = 0;
    modelOut = 0; peakOut = 0; peakUse = 0; violations = 0;
    grantBudget = -1; ackBudget = -1; rxSalt = $urandom;
  endtask

  task automatic configure(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [LW-1:0] len);
    i_dma_bank = b; i_dma_address = a; i_dma_length = len;
    i_dma_load_bank_address = 1'b1; i_dma_load_length = 1'b1;
    tick();
    i_dma_load_bank_address = 1'b0; i_dma_load_length = 1'b0;
  endtask

  task automatic startXfer(input logic dir);
    i_dma_direction = dir;
    i_dma_start = 1'b1;
    startCyc = cyc;
    tick();
    i_dma_start = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      tick();
      if (doneCount > 0 && !o_dma_busy) begin
        timedOut = 1'b0;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick(); tick();
    testsRun++;
    if ({o_dma_busy, o_dma_done, o_write, o_tx_fifo_push, o_request, o_rx_fifo_pop} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {o_dma_busy, o_dma_done, o_write, o_tx_fifo_push, o_request, o_rx_fifo_pop});
    end
    testsRun++;
    if ({o_bank, o_address} !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 0", {o_bank, o_address});
    end
    testsRun++;
    if (o_dma_left !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_left: got %0d expected 0", o_dma_left);
    end
    testsRun++;
    if (o_tx_fifo_data !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_txdata: got %h expected 0", o_tx_fifo_data);
    end
    rstN = 1'b1;
    tick(); tick();
    testsRun++;
    if (o_dma_busy !== 1'b0 || o_request !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: got busy=%b req=%b expected 0 0", o_dma_busy, o_request);
    end
  endtask

  task automatic test_write_basic();
    bit to;
    clearObs();
    busyRand = 0; rxStallRand = 0; strayAck = 1; rxAvail = 3;
    configure(4'd2, 24'h000010, 15'd3);
    startXfer(1'b1);
    waitIdle(100, to);
    strayAck = 0;
    testsRun++;
    if (to) begin testsFailed++; $display("[TB] FAIL wr_timeout: got no done expected done"); end
    testsRun++;
    if (accAddrQ.size() != 3) begin
      testsFailed++; $display("[TB] FAIL wr_count: got %0d expected 3", accAddrQ.size());
    end
    for (int i = 0; i < accAddrQ.size() && i < 3; i++) begin
      testsRun++;
      if (accAddrQ[i] !== {4'd2, 24'h10 + 24'(i)} || accDataQ[i] !== rxWord(i) || accWriteQ[i] !== 1'b1
          || accCycQ[i] != accCycQ[0] + i) begin
        testsFailed++;
        $display("[TB] FAIL wr_beat%0d: got addr=%h data=%h wr=%b cyc=%0d expected addr=%h data=%h wr=1 cyc=%0d",
                 i, accAddrQ[i], accDataQ[i], accWriteQ[i], accCycQ[i], {4'd2, 24'h10 + 24'(i)},
                 rxWord(i), accCycQ[0] + i);
      end
    end
    testsRun++;
    if (popCount != 3) begin testsFailed++; $display("[TB] FAIL wr_pops: got %0d expected 3", popCount); end
    testsRun++;
    if (doneCount != 1 || busyAtDone != 0 || (accCycQ.size() == 3 && doneCyc != accCycQ[2] + 1)) begin
      testsFailed++;
      $display("[TB] FAIL wr_done: got count=%0d busy=%0d cyc=%0d expected count=1 busy=0 one cycle after last accept",
               doneCount, busyAtDone, doneCyc);
    end
    testsRun++;
    if (o_dma_left !== '0 || pushDataQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL wr_left_push: got left=%0d pushes=%0d expected 0 0", o_dma_left, pushDataQ.size());
    end
  endtask

  task automatic test_read_latency();
    bit to;
    clearObs();
    busyRand = 0; freeVal = 16; lat = 3; latJitter = 0;
    configure(4'd7, 24'h000100, 15'd8);
    startXfer(1'b0);
    waitIdle(200, to);
    testsRun++;
    if (to || accAddrQ.size() != 8 || pushDataQ.size() != 8) begin
      testsFailed++;
      $display("[TB] FAIL rd_counts: got timeout=%0b accepts=%0d pushes=%0d expected 0 8 8",
               to, accAddrQ.size(), pushDataQ.size());
    end
    for (int i = 0; i < pushDataQ.size() && i < 8 && i < ackCycQ.size(); i++) begin
      testsRun++;
      if (pushDataQ[i] !== memWord(4'd7, 24'h100 + 24'(i)) || pushCycQ[i] != ackCycQ[i] + 1) begin
        testsFailed++;
        $display("[TB] FAIL rd_push%0d: got data=%h cyc=%0d expected data=%h cyc=%0d",
                 i, pushDataQ[i], pushCycQ[i], memWord(4'd7, 24'h100 + 24'(i)), ackCycQ[i] + 1);
      end
    end
    testsRun++;
    if (peakOut > MAXO || violations != 0) begin
      testsFailed++;
      $display("[TB] FAIL rd_outstanding: got peak=%0d violations=%0d expected peak<=%0d violations=0",
               peakOut, violations, MAXO);
    end
    testsRun++;
    if (doneCount != 1 || o_dma_left !== '0 || o_dma_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rd_done: got done=%0d left=%0d busy=%b expected 1 0 0", doneCount, o_dma_left, o_dma_busy);
    end
  endtask

  task automatic test_max_outstanding();
    bit to;
    clearObs();
    busyRand = 0; freeVal = 16; lat = 8; latJitter = 0;
    configure(4'd1, 24'h000400, 15'd12);
    startXfer(1'b0);
    waitIdle(300, to);
    testsRun++;
    if (to || peakOut != MAXO || violations != 0 || pushDataQ.size() != 12) begin
      testsFailed++;
      $display("[TB] FAIL max_outstanding: got timeout=%0b peak=%0d viol=%0d pushes=%0d expected 0 %0d 0 12",
               to, peakOut, violations, pushDataQ.size(), MAXO);
    end
  endtask

  task automatic test_credit();
    bit to;
    int peakPhase1;
    clearObs();
    busyRand = 0; freeVal = 2; lat = 2; latJitter = 0;
    configure(4'd9, 24'h000800, 15'd6);
    startXfer(1'b0);
    for (int i = 0; i < 6; i++) tick();
    peakPhase1 = peakUse;
    freeVal = 16;
    waitIdle(200, to);
    testsRun++;
    if (peakPhase1 > 2 || peakPhase1 < 1) begin
      testsFailed++;
      $display("[TB] FAIL credit_peak: got %0d expected 1..2 while free=2", peakPhase1);
    end
    testsRun++;
    if (to || violations != 0 || pushDataQ.size() != 6) begin
      testsFailed++;
      $display("[TB] FAIL credit_done: got timeout=%0b viol=%0d pushes=%0d expected 0 0 6",
               to, violations, pushDataQ.size());
    end
    for (int i = 0; i < pushDataQ.size() && i < 6; i++) begin
      testsRun++;
      if (pushDataQ[i] !== memWord(4'd9, 24'h800 + 24'(i))) begin
        testsFailed++;
        $display("[TB] FAIL credit_data%0d: got %h expected %h", i, pushDataQ[i], memWord(4'd9, 24'h800 + 24'(i)));
      end
    end
  endtask

  task automatic test_stop_read();
    bit to;
    bit reached;
    clearObs();
    busyRand = 0; freeVal = 16; lat = 1; latJitter = 0;
    grantBudget = 5; ackBudget = 2;
    configure(4'd3, 24'h000200, 15'd10);
    startXfer(1'b0);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (accAddrQ.size() == 5 && pushDataQ.size() == 2) begin reached = 1'b1; break; end
    end
    tick(); tick();
    testsRun++;
    if (!reached || modelOut != 3 || o_dma_left !== 15'd5 || o_dma_busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stop_setup: got reached=%0b outst=%0d left=%0d busy=%b expected 1 3 5 1",
               reached, modelOut, o_dma_left, o_dma_busy);
    end
    i_dma_stop = 1'b1;
    tick();
    i_dma_stop = 1'b0;
    reqHigh = 0; grantBudget = -1; ackBudget = -1;
    waitIdle(100, to);
    testsRun++;
    if (to || reqHigh != 0 || accAddrQ.size() != 5) begin
      testsFailed++;
      $display("[TB] FAIL stop_norequest: got timeout=%0b reqCycles=%0d accepts=%0d expected 0 0 5",
               to, reqHigh, accAddrQ.size());
    end
    testsRun++;
    if (pushDataQ.size() != 5 || doneCount != 1 || o_dma_left !== 15'd5) begin
      testsFailed++;
      $display("[TB] FAIL stop_drain: got pushes=%0d done=%0d left=%0d expected 5 1 5",
               pushDataQ.size(), doneCount, o_dma_left);
    end
    for (int i = 0; i < pushDataQ.size() && i < 5; i++) begin
      testsRun++;
      if (pushDataQ[i] !== memWord(4'd3, 24'h200 + 24'(i))) begin
        testsFailed++;
        $display("[TB] FAIL stop_data%0d: got %h expected %h", i, pushDataQ[i], memWord(4'd3, 24'h200 + 24'(i)));
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit to;
    logic [AW-1:0] ea;
    clearObs();
    busyRand = 1; rxStallRand = 1; rxAvail = 4;
    configure(4'd5, 24'hFFFFFE, 15'd4);
    startXfer(1'b1);
    waitIdle(200, to);
    busyRand = 0; rxStallRand = 0;
    testsRun++;
    if (to || accAddrQ.size() != 4 || popCount != 4) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count: got timeout=%0b accepts=%0d pops=%0d expected 0 4 4",
               to, accAddrQ.size(), popCount);
    end
    for (int i = 0; i < accAddrQ.size() && i < 4; i++) begin
      ea = 24'hFFFFFE + 24'(i);
      testsRun++;
      if (accAddrQ[i] !== {4'd5, ea} || accDataQ[i] !== rxWord(i)) begin
        testsFailed++;
        $display("[TB] FAIL wrap_beat%0d: got %h/%h expected %h/%h", i, accAddrQ[i], accDataQ[i], {4'd5, ea}, rxWord(i));
      end
    end
  endtask

  task automatic test_zero_length();
    clearObs();
    configure(4'd6, 24'h000020, 15'd0);
    startXfer(1'b1);
    for (int i = 0; i < 5; i++) tick();
    testsRun++;
    if (doneCount != 1 || doneCyc != startCyc + 1 || busyHigh != 0 || reqHigh != 0) begin
      testsFailed++;
      $display("[TB] FAIL zero_len: got done=%0d doneCyc=%0d busyCycles=%0d reqCycles=%0d expected 1 %0d 0 0",
               doneCount, doneCyc, busyHigh, reqHigh, startCyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clearObs();
    busyRand = 0; freeVal = 16; lat = 2; latJitter = 0;
    configure(4'd1, 24'h000040, 15'd20);
    startXfer(1'b0);
    for (int i = 0; i < 6; i++) tick();
    rstN = 1'b0;
    #1;
    testsRun++;
    if ({o_dma_busy, o_dma_done, o_write, o_tx_fifo_push, o_request, o_rx_fifo_pop} !== 6'b0
        || {o_bank, o_address} !== '0 || o_dma_left !== '0 || o_tx_fifo_data !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got flags=%b addr=%h left=%0d tx=%h expected all 0",
               {o_dma_busy, o_dma_done, o_write, o_tx_fifo_push, o_request, o_rx_fifo_pop},
               {o_bank, o_address}, o_dma_left, o_tx_fifo_data);
    end
    tick();
    clearObs();
    tick();
    rstN = 1'b1;
    tick();
    rxAvail = 2;
    configure(4'd8, 24'h000300, 15'd2);
    startXfer(1'b1);
    waitIdle(100, to);
    testsRun++;
    if (to || accAddrQ.size() != 2 || doneCount != 1 || pushDataQ.size() != 0
        || (accAddrQ.size() == 2 && accAddrQ[1] !== {4'd8, 24'h301})) begin
      testsFailed++;
      $display("[TB] FAIL after_reset_xfer: got timeout=%0b accepts=%0d done=%0d pushes=%0d expected 0 2 1 0",
               to, accAddrQ.size(), doneCount, pushDataQ.size());
    end
  endtask

  task automatic test_random();
    bit to;
    logic dir;
    logic [BW-1:0] b;
    logic [AW-1:0] a, ea;
    int len;
    for (int it = 0; it < 12; it++) begin
      clearObs();
      dir = 1'($urandom_range(0, 1));
      b = BW'($urandom);
      a = ($urandom_range(0, 1) == 1) ? (24'hFFFFF8 + 24'($urandom_range(0, 7))) : AW'($urandom);
      len = int'($urandom_range(1, 12));
      lat = int'($urandom_range(1, 4)); latJitter = int'($urandom_range(0, 2));
      freeVal = int'($urandom_range(2, 16));
      busyRand = 1; rxStallRand = 1; rxAvail = len; strayAck = dir ? 1 : 0;
      configure(b, a, LW'(len));
      startXfer(dir);
      waitIdle(600, to);
      strayAck = 0;
      testsRun++;
      if (to || accAddrQ.size() != len || doneCount != 1 || o_dma_left !== '0 || violations != 0) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_summary: got timeout=%0b accepts=%0d done=%0d left=%0d viol=%0d expected 0 %0d 1 0 0",
                 it, to, accAddrQ.size(), doneCount, o_dma_left, violations, len);
      end
      for (int i = 0; i < accAddrQ.size() && i < len; i++) begin
        ea = a + 24'(i);
        testsRun++;
        if (accAddrQ[i] !== {b, ea} || accWriteQ[i] !== dir || (dir && accDataQ[i] !== rxWord(i))) begin
          testsFailed++;
          $display("[TB] FAIL rand%0d_beat%0d: got addr=%h wr=%b data=%h expected addr=%h wr=%b",
                   it, i, accAddrQ[i], accWriteQ[i], accDataQ[i], {b, ea}, dir);
        end
      end
      testsRun++;
      if (dir ? (popCount != len || pushDataQ.size() != 0) : (popCount != 0 || pushDataQ.size() != len)) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_fifo: got pops=%0d pushes=%0d expected for dir=%b len=%0d",
                 it, popCount, pushDataQ.size(), dir, len);
      end
      if (!dir) begin
        for (int i = 0; i < pushDataQ.size() && i < ackCycQ.size(); i++) begin
          ea = a + 24'(i);
          testsRun++;
          if (pushDataQ[i] !== memWord(b, ea) || pushCycQ[i] != ackCycQ[i] + 1) begin
            testsFailed++;
            $display("[TB] FAIL rand%0d_push%0d: got data=%h cyc=%0d expected data=%h cyc=%0d",
                     it, i, pushDataQ[i], pushCycQ[i], memWord(b, ea), ackCycQ[i] + 1);
          end
        end
      end
    end
    busyRand = 0; rxStallRand = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_latency();
    test_max_outstanding();
    test_credit();
    test_stop_read();
    test_addr_wrap();
    test_zero_length();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
